divider_fixedpoint: RTL and testbench



---
 rtl/divider_fixedpoint.sv | 160 ++++++++++++++++
 tb/tb_divider_fixedpoint.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_fixedpoint.sv
// rtl/divider_fixedpoint.sv - unsigned fixed-point radix-2 restoring divider
//
// Computes q = a / b on unsigned Q(INTEGER_BITWIDTH).(FRACTION_BITWIDTH)
// operands, producing the same format. It retires one quotient bit per
// cycle and truncates the result toward zero. Overflow and divide-by-zero
// saturate q to all ones and raise a flag.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair a/b is valid
//   in_ready   divider accepts an operand pair (IDLE only)
//   a, b       dividend and divisor, N bits each
//   out_valid  q/ovf/dz are valid (DONE)
//   out_ready  consumer takes the result
//   q          quotient, N bits
//   ovf        true quotient does not fit in N bits
//   dz         divisor was zero
module divider_fixedpoint #(
  parameter int INTEGER_BITWIDTH  = 8,
  parameter int FRACTION_BITWIDTH = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [INTEGER_BITWIDTH+FRACTION_BITWIDTH-1:0] a,
  input  logic [INTEGER_BITWIDTH+FRACTION_BITWIDTH-1:0] b,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [INTEGER_BITWIDTH+FRACTION_BITWIDTH-1:0] q,
  output logic                                         ovf,
  output logic                                         dz
);

  localparam int N  = INTEGER_BITWIDTH + FRACTION_BITWIDTH;
  localparam int F  = FRACTION_BITWIDTH;
  localparam int W  = N + F;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  // RESOLVE is the single edge after the last iteration that turns the raw
  // quotient into the saturated, flagged result.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   d_q;        // dividend {a, F zeros}, shifted out MSB first
  logic [N-1:0]   b_q;        // divisor captured at acceptance
  logic [N:0]     r_q;        // partial remainder
  logic [W-1:0]   qf_q;       // raw quotient, bits enter at the LSB
  logic [CW-1:0]  cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [N-1:0]   q_q;
  logic           ovf_q;
  logic           dz_q;

  logic [N:0]     r_shift;
  logic           bit_ge;
  logic [N:0]     r_d;
  logic [W-1:0]   d_d;
  logic [W-1:0]   qf_d;

  // One restoring step. The bit shifted out of r_q[N] is folded into the
  // compare: if it was set the true shifted remainder is at least 2^(N+1),
  // so it exceeds any N-bit divisor and the modular subtraction is exact.
  always_comb begin
    r_shift = {r_q[N-1:0], d_q[W-1]};
    bit_ge  = r_q[N] | (r_shift >= {1'b0, b_q});
    r_d     = bit_ge ? (r_shift - {1'b0, b_q}) : r_shift;
    d_d     = {d_q[W-2:0], 1'b0};
    qf_d    = {qf_q[W-2:0], bit_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      d_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      qf_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            d_q        <= {a, {F{1'b0}}};
            b_q        <= b;
            r_q        <= '0;
            qf_q       <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end

        CALC: begin
          r_q  <= r_d;
          d_q  <= d_d;
          qf_q <= qf_d;
          // Counter parks at its terminal value instead of wrapping.
          if (cnt_q == CNT_LAST) begin
            state_q <= RESOLVE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        RESOLVE: begin
          if (b_q == '0) begin
            q_q   <= '1;
            ovf_q <= 1'b0;
            dz_q  <= 1'b1;
          end else if (|qf_q[W-1:N]) begin
            q_q   <= '1;
            ovf_q <= 1'b1;
            dz_q  <= 1'b0;
          end else begin
            q_q   <= qf_q[N-1:0];
            ovf_q <= 1'b0;
            dz_q  <= 1'b0;
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_divider_fixedpoint.sv
// tb/tb_divider_fixedpoint.sv - directed self-checking bench for divider_fixedpoint
module tb_divider_fixedpoint;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        ovf;
  logic        dz;

  int n_cmp;
  int n_fail;

  divider_fixedpoint #(
    .INTEGER_BITWIDTH  (8),
    .FRACTION_BITWIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts edges from the acceptance edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ref_div(input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] eq, output logic eo, output logic ed);
    logic [23:0] num;
    logic [23:0] quo;
    num = {av, 8'h00};
    ed  = (bv == 16'h0000);
    eo  = 1'b0;
    eq  = 16'hFFFF;
    if (!ed) begin
      quo = num / {8'h00, bv};
      eo  = (quo[23:16] != 8'h00);
      eq  = eo ? 16'hFFFF : quo[15:0];
    end
  endtask

  // Issues one pair, scrambles the inputs during CALC, checks latency and
  // result, optionally holds back-pressure, then completes the handshake.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] eq, input logic eo, input logic ed, input int hold);
    int lat;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~av;
    b        = bv ^ 16'h5A5A;
    check({tag, ".in_ready_calc"}, {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    check({tag, ".latency"}, lat, 32'd25);
    check({tag, ".q"}, {16'd0, q}, {16'd0, eq});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    check({tag, ".dz"}, {31'd0, dz}, {31'd0, ed});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_q"}, {16'd0, q}, {16'd0, eq});
      check({tag, ".hold_flags"}, {30'd0, ovf, dz}, {30'd0, eo, ed});
      check({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".post_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] eq;
    logic        eo;
    logic        ed;

    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.q", {16'd0, q}, 32'd0);
    check("reset.flags", {30'd0, ovf, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("nominal", 16'h0300, 16'h0180, 16'h0200, 1'b0, 1'b0, 0);
    run_op("trunc1", 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 0);
    run_op("trunc2", 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);
    run_op("ovf", 16'h8000, 16'h0080, 16'hFFFF, 1'b1, 1'b0, 0);
    run_op("ovf_edge", 16'h7FFF, 16'h0080, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("dz1", 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 0);
    run_op("dz0", 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 0);
    run_op("backpressure", 16'h0500, 16'h0200, 16'h0280, 1'b0, 1'b0, 10);

    // in_valid held high across the whole operation with a second pair
    // presented during CALC: it must not disturb the first result and must
    // be accepted one cycle after the output handshake.
    a        = 16'h0300;
    b        = 16'h0180;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h0100;
    b = 16'h0300;
    wait_valid(lat);
    check("held.lat1", lat, 32'd25);
    check("held.q1", {16'd0, q}, 32'h0200);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("held.in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("held.accepted", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    check("held.lat2", lat, 32'd25);
    check("held.q2", {16'd0, q}, 32'h0055);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset during iteration 10; q still holds 0x0055 from the last result.
    a        = 16'h0300;
    b        = 16'h0180;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid.q", {16'd0, q}, 32'd0);
    check("rst_mid.flags", {30'd0, ovf, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      check("rst_mid.no_pulse", {31'd0, out_valid}, 32'd0);
    end
    run_op("after_rst", 16'h0300, 16'h0180, 16'h0200, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      ref_div(ra, rb, eq, eo, ed);
      run_op("random", ra, rb, eq, eo, ed, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
